// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin, packet-locking arbiter sharing one uart_tx serializer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int LOCK_TO = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   cfg_databits,
    input  logic [6*N_REQ-1:0]   cfg_stopbits,
    input  logic [2*N_REQ-1:0]   cfg_parity,
    output logic [N_REQ-1:0]     grant,
    output logic                 busy,
    output logic                 uart_start_n,
    output logic [7:0]           uart_din,
    output logic [3:0]           uart_databits,
    output logic [5:0]           uart_stopbits,
    output logic [1:0]           uart_paritybit,
    input  logic                 uart_done_tick
);

    localparam int               c_PW  = $clog2(N_REQ);
    localparam int               c_TW  = (LOCK_TO > 0) ? $clog2(LOCK_TO + 1) : 1;
    localparam logic [N_REQ-1:0] c_ONE = N_REQ'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SEL   = 2'd1;
    localparam logic [1:0] c_START = 2'd2;
    localparam logic [1:0] c_WAIT  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N_REQ-1:0] r_grant;
    logic [c_PW-1:0]  r_gidx;
    logic [c_PW-1:0]  r_ptr;
    logic [c_PW-1:0]  w_ptr_nxt;
    logic [c_PW-1:0]  w_sel_idx;
    logic [c_PW:0]    w_sum;
    logic [c_TW-1:0]  r_to_cnt;
    logic             r_last;
    logic [7:0]       r_din;
    logic [3:0]       r_databits;
    logic [5:0]       r_stopbits;
    logic [1:0]       r_parity;
    logic [7:0]       w_gnt_data;
    logic             w_gnt_last;
    logic [3:0]       w_sel_db;
    logic [5:0]       w_sel_sb;
    logic [1:0]       w_sel_par;
    logic             w_found;
    logic             w_accept;
    logic             w_to_hit;
    logic [N_REQ-1:0] w_ready;

    // First valid requester at or after the round-robin pointer, with wrap.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_sum     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_PW+1)'(k);
            if (w_sum >= (c_PW+1)'(N_REQ)) begin
                w_sum = w_sum - (c_PW+1)'(N_REQ);
            end
            if (!w_found && req_valid[w_sum[c_PW-1:0]]) begin
                w_found   = 1'b1;
                w_sel_idx = w_sum[c_PW-1:0];
            end
        end
    end

    // Sanitised config of the candidate, and data/last of the current owner.
    always_comb begin
        w_sel_db   = 4'd8;
        w_sel_sb   = 6'd16;
        w_sel_par  = 2'd0;
        w_gnt_data = 8'd0;
        w_gnt_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel_idx == c_PW'(i)) begin
                w_sel_db  = (cfg_databits[4*i +: 4] == 4'd7)  ? 4'd7  : 4'd8;
                w_sel_sb  = (cfg_stopbits[6*i +: 6] == 6'd32) ? 6'd32 : 6'd16;
                w_sel_par = (cfg_parity[2*i +: 2] == 2'd3)    ? 2'd0  : cfg_parity[2*i +: 2];
            end
            if (r_gidx == c_PW'(i)) begin
                w_gnt_data = req_data[8*i +: 8];
                w_gnt_last = req_last[i];
            end
        end
    end

    assign w_ready   = (r_state == c_SEL) ? (r_grant & req_valid) : '0;
    assign w_accept  = |w_ready;
    assign w_to_hit  = (LOCK_TO != 0) && (r_to_cnt == c_TW'(LOCK_TO - 1));
    assign w_ptr_nxt = (r_gidx == c_PW'(N_REQ - 1)) ? '0 : r_gidx + c_PW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found) w_state_nxt = c_SEL;
            c_SEL: begin
                if (w_accept)      w_state_nxt = c_START;
                else if (w_to_hit) w_state_nxt = c_IDLE;
            end
            c_START: w_state_nxt = c_WAIT;
            c_WAIT: begin
                if (uart_done_tick) w_state_nxt = r_last ? c_IDLE : c_SEL;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_gidx     <= '0;
            r_ptr      <= '0;
            r_to_cnt   <= '0;
            r_last     <= 1'b0;
            r_din      <= 8'd0;
            r_databits <= 4'd8;
            r_stopbits <= 6'd16;
            r_parity   <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant    <= c_ONE << w_sel_idx;
                        r_gidx     <= w_sel_idx;
                        r_databits <= w_sel_db;
                        r_stopbits <= w_sel_sb;
                        r_parity   <= w_sel_par;
                    end
                end
                c_SEL: begin
                    if (w_accept) begin
                        r_din    <= w_gnt_data;
                        r_last   <= w_gnt_last;
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        // Stalled owner loses the lock and drops to lowest priority.
                        r_grant  <= '0;
                        r_ptr    <= w_ptr_nxt;
                        r_to_cnt <= '0;
                    end else if (LOCK_TO != 0) begin
                        r_to_cnt <= r_to_cnt + c_TW'(1);
                    end
                end
                c_WAIT: begin
                    if (uart_done_tick && r_last) begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready      = w_ready;
    assign grant          = r_grant;
    assign busy           = (r_state != c_IDLE);
    assign uart_start_n   = (r_state != c_START);
    assign uart_din       = r_din;
    assign uart_databits  = r_databits;
    assign uart_stopbits  = r_stopbits;
    assign uart_paritybit = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter with a uart_tx stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [4*N-1:0] cfg_databits;
    logic [6*N-1:0] cfg_stopbits;
    logic [2*N-1:0] cfg_parity;
    logic [N-1:0]   grant;
    logic           busy;
    logic           uart_start_n;
    logic [7:0]     uart_din;
    logic [3:0]     uart_databits;
    logic [5:0]     uart_stopbits;
    logic [1:0]     uart_paritybit;
    logic           uart_done_tick;

    int n_vec = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TO(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .cfg_databits   (cfg_databits),
        .cfg_stopbits   (cfg_stopbits),
        .cfg_parity     (cfg_parity),
        .grant          (grant),
        .busy           (busy),
        .uart_start_n   (uart_start_n),
        .uart_din       (uart_din),
        .uart_databits  (uart_databits),
        .uart_stopbits  (uart_stopbits),
        .uart_paritybit (uart_paritybit),
        .uart_done_tick (uart_done_tick)
    );

    // Serializer stand-in: done tick FRAME cycles after the start pulse.
    int   r_frame_cnt;
    logic r_in_frame;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_done_tick <= 1'b0;
            r_in_frame     <= 1'b0;
            r_frame_cnt    <= 0;
        end else begin
            uart_done_tick <= 1'b0;
            if (!uart_start_n) begin
                r_in_frame  <= 1'b1;
                r_frame_cnt <= FRAME;
            end else if (r_in_frame) begin
                if (r_frame_cnt == 1) begin
                    uart_done_tick <= 1'b1;
                    r_in_frame     <= 1'b0;
                end else begin
                    r_frame_cnt <= r_frame_cnt - 1;
                end
            end
        end
    end

    // Protocol watchers: one-hot ready, single-cycle start, outputs frozen in a frame.
    int         viol_rdy = 0;
    int         viol_start = 0;
    int         viol_hold = 0;
    logic       prev_start_low;
    logic       hold;
    logic [19:0] snap;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_start_low <= 1'b0;
            hold           <= 1'b0;
            snap           <= '0;
        end else begin
            if ($countones(req_ready) > 1) viol_rdy <= viol_rdy + 1;
            if (!uart_start_n && prev_start_low) viol_start <= viol_start + 1;
            prev_start_low <= !uart_start_n;
            if (!uart_start_n) begin
                hold <= 1'b1;
                snap <= {uart_din, uart_databits, uart_stopbits, uart_paritybit};
            end else if (hold) begin
                if (snap != {uart_din, uart_databits, uart_stopbits, uart_paritybit})
                    viol_hold <= viol_hold + 1;
                if (uart_done_tick) hold <= 1'b0;
            end
        end
    end

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic [3:0] db;
        logic [5:0] sb;
        logic [1:0] par;
        logic [3:0] e_db;
        logic [5:0] e_sb;
        logic [1:0] e_par;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic v, input logic [7:0] d, input logic l);
        req_valid[ch]          = v;
        req_data[8*ch +: 8]    = d;
        req_last[ch]           = l;
    endtask

    task automatic set_cfg(input int ch, input logic [3:0] db, input logic [5:0] sb,
                           input logic [1:0] par);
        cfg_databits[4*ch +: 4] = db;
        cfg_stopbits[6*ch +: 6] = sb;
        cfg_parity[2*ch +: 2]   = par;
    endtask

    task automatic wait_ready(input string nm, input logic [3:0] exp_mask, input int exp_lat);
        int k = 0;
        @(negedge clk);
        while (req_ready == '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (exp_lat >= 0) chk({nm, "_lat"}, 32'(k), 32'(exp_lat));
        chk({nm, "_ready"}, 32'(req_ready), 32'(exp_mask));
        chk({nm, "_grant"}, 32'(grant), 32'(exp_mask));
    endtask

    task automatic check_start(input string nm, input logic [7:0] din);
        @(negedge clk);
        chk({nm, "_start_n"}, 32'(uart_start_n), 32'd0);
        chk({nm, "_din"}, 32'(uart_din), 32'(din));
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (uart_done_tick !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_done"}, 32'(uart_done_tick), 32'd1);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_grant"}, 32'(grant), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_ready"}, 32'(req_ready), 32'd0);
        chk({nm, "_start_n"}, 32'(uart_start_n), 32'd1);
        chk({nm, "_cfg"}, {12'd0, uart_din, uart_databits, uart_stopbits, uart_paritybit},
            {12'd0, 8'h00, 4'd8, 6'd16, 2'd0});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        req_valid    = '0;
        req_data     = '0;
        req_last     = '0;
        cfg_databits = {N{4'hF}};
        cfg_stopbits = {N{6'h3F}};
        cfg_parity   = {N{2'h3}};

        //          ch  data   db     sb      par    e_db   e_sb    e_par
        vecs[0] = '{0, 8'hA5, 4'd8, 6'd16, 2'd0, 4'd8, 6'd16, 2'd0};
        vecs[1] = '{1, 8'h3C, 4'd7, 6'd32, 2'd1, 4'd7, 6'd32, 2'd1};
        vecs[2] = '{2, 8'hFF, 4'd5, 6'd20, 2'd3, 4'd8, 6'd16, 2'd0};
        vecs[3] = '{3, 8'h00, 4'd9, 6'd0,  2'd2, 4'd8, 6'd16, 2'd2};
        vecs[4] = '{0, 8'h7E, 4'd7, 6'd16, 2'd3, 4'd7, 6'd16, 2'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-requester packets with configuration sanitisation.
        for (int v = 0; v < 5; v++) begin
            @(posedge clk); #1;
            set_cfg(vecs[v].ch, vecs[v].db, vecs[v].sb, vecs[v].par);
            set_req(vecs[v].ch, 1'b1, vecs[v].data, 1'b1);
            wait_ready("vec", 4'b0001 << vecs[v].ch, 1);
            @(posedge clk); #1;
            set_req(vecs[v].ch, 1'b0, 8'h00, 1'b0);
            check_start("vec", vecs[v].data);
            chk("vec_databits", 32'(uart_databits), 32'(vecs[v].e_db));
            chk("vec_stopbits", 32'(uart_stopbits), 32'(vecs[v].e_sb));
            chk("vec_parity", 32'(uart_paritybit), 32'(vecs[v].e_par));
            wait_done("vec");
            @(negedge clk);
            chk("vec_idle_grant", 32'(grant), 32'd0);
            chk("vec_idle_busy", 32'(busy), 32'd0);
        end

        // Contention from pointer 0: ch1 then ch3.
        @(posedge clk); #1;
        do_reset();
        set_req(1, 1'b1, 8'h11, 1'b1);
        set_req(3, 1'b1, 8'h33, 1'b1);
        wait_ready("cont1", 4'b0010, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 8'h00, 1'b0);
        check_start("cont1", 8'h11);
        wait_done("cont1");
        wait_ready("cont3", 4'b1000, 1);
        @(posedge clk); #1;
        set_req(3, 1'b0, 8'h00, 1'b0);
        check_start("cont3", 8'h33);
        wait_done("cont3");

        // Packet lock: ch0 three bytes while ch2 waits; pointer back at 0 picks ch0.
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h11, 1'b0);
        set_req(2, 1'b1, 8'h99, 1'b1);
        wait_ready("lock1", 4'b0001, 1);
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h22, 1'b0);
        check_start("lock1", 8'h11);
        wait_done("lock1");
        wait_ready("lock2", 4'b0001, 0);
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'h33, 1'b1);
        check_start("lock2", 8'h22);
        wait_done("lock2");
        wait_ready("lock3", 4'b0001, 0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h00, 1'b0);
        check_start("lock3", 8'h33);
        wait_done("lock3");
        wait_ready("lock_ch2", 4'b0100, 1);
        @(posedge clk); #1;
        set_req(2, 1'b0, 8'h00, 1'b0);
        check_start("lock_ch2", 8'h99);
        wait_done("lock_ch2");

        // Configuration hold while inputs toggle mid-frame.
        @(posedge clk); #1;
        set_cfg(2, 4'd7, 6'd32, 2'd2);
        set_req(2, 1'b1, 8'hC7, 1'b1);
        wait_ready("hold", 4'b0100, 1);
        @(posedge clk); #1;
        set_req(2, 1'b0, 8'h00, 1'b0);
        check_start("hold", 8'hC7);
        n = 0;
        while (uart_done_tick !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            cfg_databits = ~cfg_databits;
            cfg_stopbits = ~cfg_stopbits;
            cfg_parity   = ~cfg_parity;
            @(negedge clk);
            n++;
        end
        chk("hold_done", 32'(uart_done_tick), 32'd1);
        chk("hold_cfg", {20'd0, uart_databits, uart_stopbits, uart_paritybit},
            {20'd0, 4'd7, 6'd32, 2'd2});

        // Lock timeout: ch1 stalls after a non-last byte, ch2 takes over.
        @(posedge clk); #1;
        set_req(1, 1'b1, 8'h5A, 1'b0);
        set_req(2, 1'b1, 8'h77, 1'b1);
        wait_ready("to1", 4'b0010, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 8'h00, 1'b0);
        check_start("to1", 8'h5A);
        wait_done("to1");
        repeat (8) @(negedge clk);
        chk("to_still_locked", 32'(grant), 32'b0010);
        @(negedge clk);
        chk("to_released_grant", 32'(grant), 32'd0);
        chk("to_released_busy", 32'(busy), 32'd0);
        wait_ready("to2", 4'b0100, 0);
        @(posedge clk); #1;
        set_req(2, 1'b0, 8'h00, 1'b0);
        check_start("to2", 8'h77);
        wait_done("to2");

        // Asynchronous reset in the middle of a frame, then a fresh request.
        @(posedge clk); #1;
        set_cfg(3, 4'd7, 6'd32, 2'd1);
        set_req(3, 1'b1, 8'hC3, 1'b1);
        wait_ready("rst", 4'b1000, 1);
        @(posedge clk); #1;
        set_req(3, 1'b0, 8'h00, 1'b0);
        check_start("rst", 8'hC3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_cfg(1, 4'd8, 6'd16, 2'd0);
        set_req(1, 1'b1, 8'h42, 1'b1);
        wait_ready("post", 4'b0010, 1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 8'h00, 1'b0);
        check_start("post", 8'h42);
        wait_done("post");
        @(negedge clk);
        chk("post_idle_grant", 32'(grant), 32'd0);
        chk("post_idle_busy", 32'(busy), 32'd0);

        chk("ready_onehot", 32'(viol_rdy), 32'd0);
        chk("start_single_cycle", 32'(viol_start), 32'd0);
        chk("frame_outputs_stable", 32'(viol_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among N_REQ byte requesters using round-robin arbitration with packet locking.
- Per requester, it latches the frame configuration (data bits, stop ticks, parity) at grant and holds it stable for the whole packet.
- It sequences the serializer's start/done handshake and keeps the data and configuration steady until each frame's done tick.
- It sits between the per-channel producers (FIFOs/command logic) and uart_tx in the full-featured UART.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LOCK_TO, 1024, idle cycles a locked requester may stall mid-packet before the lock is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  requester i has a byte on req_data
- req_data  in  8*N_REQ  byte for requester i, in slice [8i+7:8i]
- req_last  in  N_REQ  byte is the last of the packet
- req_ready  out  N_REQ  one-cycle pulse: byte of requester i accepted
- cfg_databits  in  4*N_REQ  per-requester data bits (7 or 8)
- cfg_stopbits  in  6*N_REQ  per-requester stop ticks (16 or 32)
- cfg_parity  in  2*N_REQ  per-requester parity: 0 none, 1 odd, 2 even
- grant  out  N_REQ  one-hot current owner; 0 when idle
- busy  out  1  any state other than IDLE
- uart_start_n  out  1  to uart_tx tx_start; low for exactly one cycle per frame
- uart_din  out  8  to uart_tx din
- uart_databits  out  4  to uart_tx databits
- uart_stopbits  out  6  to uart_tx stopbits
- uart_paritybit  out  2  to uart_tx paritybit
- uart_done_tick  in  1  from uart_tx tx_done_tick

Behaviour:
- Reset values (asynchronous): state IDLE, grant=0, req_ready=0, busy=0, uart_start_n=1, uart_din=0, uart_databits=8, uart_stopbits=16, uart_paritybit=0, RR pointer=0, timeout counter=0.
- Reset mid-frame aborts immediately. The serializer shares rst_n, so no resync is needed.
- FSM states: IDLE, SEL, START, WAIT.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from the RR pointer upward with wrap.
  - Register its one-hot grant.
  - Latch its configuration with sanitisation: databits other than 7 → 8; stopbits other than 32 → 16; parity 3 → 0.
  - Go to SEL.
- SEL:
  - If req_valid[g]=1: pulse req_ready[g] in this cycle, latch req_data into uart_din, latch req_last, clear the timeout counter, go to START.
  - Otherwise increment the timeout counter. If LOCK_TO≠0 and the counter reaches LOCK_TO: drop the lock (grant=0), set RR pointer = g+1 mod N_REQ, go to IDLE.
- START: drive uart_start_n=0 for this single cycle, go to WAIT.
- WAIT:
  - Hold uart_din and the configuration outputs stable.
  - On uart_done_tick: if the latched last=1, set grant=0, RR pointer = g+1 mod N_REQ, go to IDLE. Otherwise go to SEL with the same grant (packet lock).
- Latency:
  - First byte: valid in IDLE → grant at +1 → ready at +1 (the SEL cycle) → uart_start_n low at +2.
  - Next byte of a packet: done tick → SEL → START, i.e. start 2 cycles after the done tick if valid is already high.
- Configuration outputs change only in IDLE→SEL. They never change between START and the done tick.
- Simultaneous requests: the RR pointer decides. A requester that just finished a packet has lowest priority next round.
- Simultaneous events:
  - A done tick outside WAIT is ignored.
  - req_valid of non-granted requesters is ignored while a lock is held.
  - req_ready is never asserted for more than one requester or for more than one cycle per byte.
- Single-byte packet: req_last=1 on the first byte releases the lock after that frame.

Test Plan:
- Single requester: ch0 sends 0xA5 with last=1, config 8/16/0 → one uart_start_n low pulse, uart_din=0xA5 until done, then grant=0 and busy=0.
- Contention: ch1 and ch3 are valid, pointer=0, each sends a 1-byte packet → ch1 is served first, then ch3; pointer ends at 0.
- Packet lock: ch0 sends a 3-byte packet (last on byte 3) while ch2 is valid throughout → ch0 bytes 0x11, 0x22, 0x33 go out back-to-back, then ch2 is granted.
- Configuration hold: ch2 is granted with 7/32/2; cfg inputs are toggled mid-frame → uart_* configuration stays 7/32/2 until the done tick.
- Timeout: ch1 sends 1 byte with last=0, then drops valid; LOCK_TO=8 → grant is released 8 cycles after entering SEL, and ch2 (waiting) is granted next.
- Reset mid-WAIT: assert rst_n=0 → all outputs return to reset values asynchronously; after release, a fresh request is served normally.
